qubit_prob_pwm: RTL
===================

Name: qubit_prob_pwm

Overview:
- Parametrised successor to the single-qubit Hadamard-to-square-wave demo.
- Accepts one qubit state: amplitudes (x0+j·y0)|0> + (x1+j·y1)|1>, fixed-point Q(W-FRAC).FRAC.
- Optionally applies a Hadamard gate, then computes the measurement probabilities p0 and p1 through a sequenced 3-stage datapath.
- Drives two PWM outputs whose duty cycles equal p0 and p1, updated glitch-free at period boundaries, for display on a DSO or LEDs.

Parameters:
- W, 13, signed amplitude width including sign.
- FRAC, 11, fraction bits; 1.0 = 2^FRAC = 2048.
- HCOEF, 1448, 1/sqrt(2) in Q.FRAC (0x5A8).
- PERIOD, 2_500_000, PWM period in clk cycles (>= 2).
- CNT_W, clog2(PERIOD+1), counter/threshold width (derived localparam).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  state offered
- in_ready  out  1  block idle, can accept
- apply_h  in  1  1: apply Hadamard before measurement; 0: measure directly; sampled with the state
- x0, y0, x1, y1  in  W  signed amplitudes, two's complement
- p0, p1  out  W  unsigned probabilities in Q.FRAC, range 0..2^FRAC
- prob_valid  out  1  one-cycle pulse, p0/p1 updated
- pwm0, pwm1  out  1  duty = p0, p1
- period_tick  out  1  one-cycle pulse on last cycle of each PWM period

Behaviour:
- Reset (async): FSM=IDLE, in_ready=1, p0=p1=0, prob_valid=0, pwm0=pwm1=0, period_tick=0, counter=0, all thresholds (pending, active)=0. Reset mid-compute aborts it; no prob_valid is produced.
- FSM states: IDLE -> MIX -> SQR -> SUM -> IDLE, one cycle each. in_ready = (state==IDLE).
- Accept: on an edge with in_ready and in_valid, register inputs and go to MIX. in_valid is ignored while busy; no queueing.
- MIX, apply_h=1:
  - a0 = ((x0+x1)·HCOEF)>>>FRAC, b0 = ((y0+y1)·HCOEF)>>>FRAC
  - a1 = ((x0-x1)·HCOEF)>>>FRAC, b1 = ((y0-y1)·HCOEF)>>>FRAC
  - Sums and differences use W+1 bits; products use 2W+2 bits. Arithmetic shift truncates toward -inf. Results fit in W+1 bits.
- MIX, apply_h=0: a0=x0, b0=y0, a1=x1, b1=y1 (sign-extended).
- SQR: sq_k = (v·v)>>FRAC for each of a0, b0, a1, b1. Results are non-negative.
- SUM: s0 = sq_a0+sq_b0, s1 = sq_a1+sq_b1. Each saturates to 2^FRAC (no normalisation; unnormalised states clip at 1.0).
- Compute thr_k = (PERIOD·s_k)>>FRAC, truncated; range 0..PERIOD.
- Edge leaving SUM: p0/p1 <= saturated sums; thr_pending <= thr; prob_valid=1 for exactly that one cycle; in_ready=1 in the same cycle.
- Latency: prob_valid is high 3 cycles after the accept edge. Maximum throughput is one state per 4 cycles. p0/p1 hold until the next result.
- PWM counter: 0..PERIOD-1, free-running, wraps to 0. period_tick = (counter==PERIOD-1), combinational from the counter.
- Threshold update:
  - On the wrap edge, thr_active <= the newest value. If the result lands on that same edge, the new thr is used; otherwise thr_pending.
  - A new result therefore first shows in the period starting at the next wrap. No mid-period duty change.
- PWM output: pwm_k registered, pwm_k <= (next_counter < thr_active_next).
  - thr=0: constant low. thr=PERIOD: constant high, no glitch at wrap.
- Results completing mid-period: the last one before the wrap wins; intermediate values are discarded.

Decomposition:
- Shared package qsim_pkg holds:
  - Fixed-point constants: FRAC, ONE = 2^FRAC, HCOEF.
  - Amplitude typedef amp_t (signed W).
  - Probability typedef prob_t (unsigned W).
  - The shared multiply-shift function, already used by the Hadamard and multiplier blocks.
- One sub-module, pwm_channel (parameter PERIOD): counter, pending/active threshold, output. Instantiate twice, sharing one counter, or pass period_tick in. The datapath FSM stays in the top level.

Test Plan (PERIOD=1000 for sim):
- Reset applied mid-SQR -> no prob_valid; after release in_ready=1, all outputs 0, pwm0=pwm1=0 for >= 2 periods.
- x0=2048, others 0, apply_h=1 -> prob_valid 3 cycles after accept; p0=p1=1023; after the next wrap pwm0/pwm1 high exactly 499 of 1000 cycles.
- x0=2048, others 0, apply_h=0 -> p0=2048, p1=0; pwm0 constant 1 across wrap with no low glitch; pwm1 constant 0.
- x1=-2048 (13'h1800), others 0, apply_h=1 -> internal a0=-1448, a1=1448; p0=p1=1023.
- x0=y0=2048, apply_h=0 -> s0=4096 saturates; p0=2048, thr=1000.
- Handshake and boundary timing:
  - Hold in_valid high continuously -> accepts spaced exactly 4 cycles; in_ready low for 3 cycles after each accept.
  - Result landing on the wrap edge is used in the new period.
  - Result landing 1 cycle after the wrap waits a full period.

Source files
------------

// File: rtl/qsim_pkg.sv
// Shared fixed-point constants, types, FSM encoding and multiply-shift helper
// for the qubit probability / PWM demo.
package qsim_pkg;
    localparam int W     = 13;
    localparam int FRAC  = 11;
    localparam int ONE   = 1 << FRAC;
    localparam int HCOEF = 1448;

    typedef logic signed [W-1:0] amp_t;
    typedef logic        [W-1:0] prob_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MIX  = 2'd1,
        ST_SQR  = 2'd2,
        ST_SUM  = 2'd3
    } dp_state_e;

    // Signed product then arithmetic right shift, so results round toward minus infinity.
    function automatic logic signed [31:0] mul_shift(input logic signed [31:0] a,
                                                     input logic signed [31:0] b,
                                                     input int                 sh);
        logic signed [63:0] prod;
        prod = 64'(a) * 64'(b);
        return 32'(prod >>> sh);
    endfunction
endpackage

// File: rtl/pwm_channel.sv
// One PWM output: a pending threshold captured from each result and an active
// threshold that only changes at the period wrap, so the duty never changes mid-period.
module pwm_channel #(
    parameter int PERIOD = 1000,
    parameter int CNT_W  = $clog2(PERIOD + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_i,
    input  logic [CNT_W-1:0] cnt_next_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] thr_i,
    output logic             pwm_o
);
    logic [CNT_W-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic             pwm_q, pwm_d;

    always_comb begin
        pend_d = load_i ? thr_i : pend_q;
        // A result landing on the wrap edge goes straight into the new period.
        act_d  = tick_i ? pend_d : act_q;
        pwm_d  = (cnt_next_i < act_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
            act_q  <= '0;
            pwm_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            act_q  <= act_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;
endmodule

// File: rtl/qubit_prob_pwm.sv
// Single-qubit measurement demo: optional Hadamard, |amp|^2 probabilities, two PWM outputs.
// state | meaning
// IDLE  | ready; captures amplitudes and apply_h on in_valid
// MIX   | Hadamard (or pass-through) into a0/b0/a1/b1
// SQR   | square each real/imaginary component
// SUM   | add, saturate to 1.0, publish p0/p1 and PWM thresholds
module qubit_prob_pwm #(
    parameter int W      = qsim_pkg::W,
    parameter int FRAC   = qsim_pkg::FRAC,
    parameter int HCOEF  = qsim_pkg::HCOEF,
    parameter int PERIOD = 2_500_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                apply_h,
    input  logic signed [W-1:0] x0,
    input  logic signed [W-1:0] y0,
    input  logic signed [W-1:0] x1,
    input  logic signed [W-1:0] y1,
    output logic        [W-1:0] p0,
    output logic        [W-1:0] p1,
    output logic                prob_valid,
    output logic                pwm0,
    output logic                pwm1,
    output logic                period_tick
);
    import qsim_pkg::*;

    localparam int SW    = W + 1;
    localparam int SQ_W  = 2 * SW - FRAC;
    localparam int CNT_W = $clog2(PERIOD + 1);
    localparam int SAT   = 1 << FRAC;

    dp_state_e            state_q, state_d;
    logic signed [W-1:0]  x0_q, y0_q, x1_q, y1_q;
    logic                 h_q;
    logic signed [SW-1:0] sx, sy, dx, dy;
    logic signed [SW-1:0] a0_q, b0_q, a1_q, b1_q;
    logic signed [SW-1:0] a0_d, b0_d, a1_d, b1_d;
    logic [SQ_W-1:0]      sa0_q, sb0_q, sa1_q, sb1_q;
    logic [SQ_W-1:0]      sa0_d, sb0_d, sa1_d, sb1_d;
    logic [31:0]          s0, s1, s0_sat, s1_sat;
    logic [W-1:0]         p0_q, p1_q, p0_d, p1_d;
    logic [CNT_W-1:0]     thr0, thr1, cnt_q, cnt_d;
    logic                 pv_q, pv_d, accept, load;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_MIX;
                    accept  = 1'b1;
                end
            end
            ST_MIX:  state_d = ST_SQR;
            ST_SQR:  state_d = ST_SUM;
            ST_SUM:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign load = (state_q == ST_SUM);
    assign pv_d = load;

    always_comb begin
        sx = SW'(x0_q) + SW'(x1_q);
        sy = SW'(y0_q) + SW'(y1_q);
        dx = SW'(x0_q) - SW'(x1_q);
        dy = SW'(y0_q) - SW'(y1_q);
        if (h_q) begin
            a0_d = SW'(mul_shift(32'(sx), HCOEF, FRAC));
            b0_d = SW'(mul_shift(32'(sy), HCOEF, FRAC));
            a1_d = SW'(mul_shift(32'(dx), HCOEF, FRAC));
            b1_d = SW'(mul_shift(32'(dy), HCOEF, FRAC));
        end else begin
            a0_d = SW'(x0_q);
            b0_d = SW'(y0_q);
            a1_d = SW'(x1_q);
            b1_d = SW'(y1_q);
        end
    end

    always_comb begin
        sa0_d = SQ_W'(mul_shift(32'(a0_q), 32'(a0_q), FRAC));
        sb0_d = SQ_W'(mul_shift(32'(b0_q), 32'(b0_q), FRAC));
        sa1_d = SQ_W'(mul_shift(32'(a1_q), 32'(a1_q), FRAC));
        sb1_d = SQ_W'(mul_shift(32'(b1_q), 32'(b1_q), FRAC));
    end

    // Unnormalised states clip at 1.0 rather than being renormalised.
    always_comb begin
        s0     = 32'(sa0_q) + 32'(sb0_q);
        s1     = 32'(sa1_q) + 32'(sb1_q);
        s0_sat = (s0 > 32'(SAT)) ? 32'(SAT) : s0;
        s1_sat = (s1 > 32'(SAT)) ? 32'(SAT) : s1;
        p0_d   = W'(s0_sat);
        p1_d   = W'(s1_sat);
        thr0   = CNT_W'((64'(PERIOD) * 64'(s0_sat)) >> FRAC);
        thr1   = CNT_W'((64'(PERIOD) * 64'(s1_sat)) >> FRAC);
    end

    assign period_tick = (cnt_q == CNT_W'(PERIOD - 1));
    assign cnt_d       = period_tick ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            h_q     <= 1'b0;
            a0_q    <= '0;
            b0_q    <= '0;
            a1_q    <= '0;
            b1_q    <= '0;
            sa0_q   <= '0;
            sb0_q   <= '0;
            sa1_q   <= '0;
            sb1_q   <= '0;
            p0_q    <= '0;
            p1_q    <= '0;
            pv_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pv_q    <= pv_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                x0_q <= x0;
                y0_q <= y0;
                x1_q <= x1;
                y1_q <= y1;
                h_q  <= apply_h;
            end
            if (state_q == ST_MIX) begin
                a0_q <= a0_d;
                b0_q <= b0_d;
                a1_q <= a1_d;
                b1_q <= b1_d;
            end
            if (state_q == ST_SQR) begin
                sa0_q <= sa0_d;
                sb0_q <= sb0_d;
                sa1_q <= sa1_d;
                sb1_q <= sb1_d;
            end
            if (load) begin
                p0_q <= p0_d;
                p1_q <= p1_d;
            end
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign prob_valid = pv_q;
    assign p0         = p0_q;
    assign p1         = p1_q;

    pwm_channel #(.PERIOD(PERIOD), .CNT_W(CNT_W)) u_pwm0 (
        .clk        (clk),
        .reset      (reset),
        .tick_i     (period_tick),
        .cnt_next_i (cnt_d),
        .load_i     (load),
        .thr_i      (thr0),
        .pwm_o      (pwm0)
    );

    pwm_channel #(.PERIOD(PERIOD), .CNT_W(CNT_W)) u_pwm1 (
        .clk        (clk),
        .reset      (reset),
        .tick_i     (period_tick),
        .cnt_next_i (cnt_d),
        .load_i     (load),
        .thr_i      (thr1),
        .pwm_o      (pwm1)
    );
endmodule
